// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: default field widths, bubble encoding and the
// occupancy states of the IF/ID register, encoded as {main_valid, skid_valid}.
package if_id_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;

  // MIPS sll $0,$0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a one-beat skid entry so in_ready is a flop,
// synchronous flush that leaves a bubble, and a saturating stall counter.
module if_id_pipe_reg
  import if_id_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int                 CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [CNT_W-1:0]   stall_count
);

  // Handshake: a beat moves on a side when valid and ready are both high in
  // the same cycle; a producer holding valid must keep its data stable.
  state_t             state_q;
  state_t             state_nxt;
  logic               main_valid;
  logic               skid_valid;
  logic               accept;
  logic               consume;
  logic               load_in;
  logic               load_from_skid;
  logic               load_skid;
  logic               drop_main;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready   = ~skid_valid & ~rst;
  assign out_valid  = main_valid;
  assign accept     = in_valid & in_ready;
  assign consume    = main_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    drop_main      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
      drop_main = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_in   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (consume) begin
            drop_main = 1'b1;
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            load_from_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: begin
          drop_main = 1'b1;
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // pc_out keeps its last value across bubbles; only the instruction is killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out          <= RESET_PC;
      instruction_out <= NOP_INSTR;
      skid_pc         <= '0;
      skid_instr      <= '0;
    end else begin
      if (load_in) begin
        pc_out          <= pc_in;
        instruction_out <= instruction_in;
      end else if (load_from_skid) begin
        pc_out          <= skid_pc;
        instruction_out <= skid_instr;
      end else if (drop_main) begin
        instruction_out <= NOP_INSTR;
      end
      if (load_skid) begin
        skid_pc    <= pc_in;
        skid_instr <= instruction_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({main_valid, skid_valid} != 2'b01);
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_valid & ~out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a default build and a narrow-PC / CNT_W=4 build
// driven in lockstep and checked against a two-deep FIFO queue model.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;

  logic        in_ready_a, out_valid_a;
  logic [31:0] pc_a, instr_a;
  logic [15:0] stall_a;
  logic        in_ready_b, out_valid_b;
  logic [29:0] pc_b;
  logic [31:0] instr_b;
  logic [3:0]  stall_b;

  int tests = 0;
  int fails = 0;

  // model state: queue of {pc, instr} beats held by the register
  logic [63:0] exp_q[$];
  logic [31:0] last_pc;
  int          stall_exp_a;
  int          stall_exp_b;

  always #5 clk = ~clk;

  if_id_pipe_reg u_dut_a (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready_a),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .out_valid       (out_valid_a),
    .out_ready       (out_ready),
    .pc_out          (pc_a),
    .instruction_out (instr_a),
    .stall_count     (stall_a)
  );

  if_id_pipe_reg #(
    .PC_W      (30),
    .INSTR_W   (32),
    .NOP_INSTR (32'h0000_0020),
    .RESET_PC  (30'h0),
    .CNT_W     (4)
  ) u_dut_b (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready_b),
    .pc_in           (pc_in[29:0]),
    .instruction_in  (instruction_in),
    .out_valid       (out_valid_b),
    .out_ready       (out_ready),
    .pc_out          (pc_b),
    .instruction_out (instr_b),
    .stall_count     (stall_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        v;
    logic        rdy;
    logic [31:0] ins_a;
    logic [31:0] ins_b;
    v     = (exp_q.size() > 0);
    rdy   = (exp_q.size() < 2) && !rst;
    ins_a = v ? exp_q[0][31:0] : 32'h0000_0000;
    ins_b = v ? exp_q[0][31:0] : 32'h0000_0020;
    chk({tag, ".valid_a"}, 64'(out_valid_a), 64'(v));
    chk({tag, ".valid_b"}, 64'(out_valid_b), 64'(v));
    chk({tag, ".ready_a"}, 64'(in_ready_a), 64'(rdy));
    chk({tag, ".ready_b"}, 64'(in_ready_b), 64'(rdy));
    chk({tag, ".pc_a"}, 64'(pc_a), 64'(last_pc));
    chk({tag, ".pc_b"}, 64'(pc_b), 64'(last_pc[29:0]));
    chk({tag, ".instr_a"}, 64'(instr_a), 64'(ins_a));
    chk({tag, ".instr_b"}, 64'(instr_b), 64'(ins_b));
    chk({tag, ".stall_a"}, 64'(stall_a), 64'(stall_exp_a));
    chk({tag, ".stall_b"}, 64'(stall_b), 64'(stall_exp_b));
  endtask

  // one clock: model the edge from the inputs currently applied, then check
  task automatic tick(input string tag);
    bit acc, con, stl;
    con = (exp_q.size() > 0) && out_ready;
    acc = in_valid && (exp_q.size() < 2) && !rst;
    stl = (exp_q.size() > 0) && !out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc_in, instruction_in});
    end
    if (stl) begin
      if (stall_exp_a < 65535) stall_exp_a++;
      if (stall_exp_b < 15) stall_exp_b++;
    end
    if (exp_q.size() > 0) last_pc = exp_q[0][63:32];
    check_outputs(tag);
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    in_valid       = v;
    pc_in          = pc;
    instruction_in = ins;
    out_ready      = ordy;
    flush          = fl;
  endtask

  // asserted between edges: outputs must clear without waiting for a clock
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    exp_q.delete();
    last_pc     = 32'h0;
    stall_exp_a = 0;
    stall_exp_b = 0;
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick({tag, ".release"});
    chk({tag, ".ready_after"}, 64'(in_ready_a), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    exp_q.delete();
    last_pc     = 32'h0;
    stall_exp_a = 0;
    stall_exp_b = 0;
    #2;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick("por.release");

    // backpressure: 0x0C is presented until the register takes it
    drive(1'b1, 32'h04, 32'h8C01_0000, 1'b0, 1'b0);
    tick("bp0");
    drive(1'b1, 32'h08, 32'h8C01_0001, 1'b0, 1'b0);
    tick("bp1");
    drive(1'b1, 32'h0C, 32'h8C01_0002, 1'b0, 1'b0);
    tick("bp2");
    chk("bp.stall2", 64'(stall_a), 64'd2);
    chk("bp.full_not_ready", 64'(in_ready_a), 64'd0);
    tick("bp3");
    drive(1'b1, 32'h0C, 32'h8C01_0002, 1'b1, 1'b0);
    tick("bp4");
    chk("bp.first_out", 64'(pc_a), 64'h08);
    tick("bp5");
    chk("bp.third_out", 64'(pc_a), 64'h0C);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("bp6");
    tick("bp7");

    // streaming at full rate
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'h8C01_0000 + 32'(i), 1'b1, 1'b0);
      tick("stream");
      chk("stream.pc", 64'(pc_a), 64'(4 * (i + 1)));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("stream.drain0");
    tick("stream.drain1");

    // reset while FULL
    drive(1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    tick("rm0");
    drive(1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0);
    tick("rm1");
    do_reset("rm");

    // flush while FULL with input presented
    drive(1'b1, 32'h20, 32'h2222_0020, 1'b0, 1'b0);
    tick("fl0");
    drive(1'b1, 32'h24, 32'h2222_0024, 1'b0, 1'b0);
    tick("fl1");
    drive(1'b1, 32'h28, 32'h2222_0028, 1'b0, 1'b1);
    tick("fl_full");
    chk("fl_full.bubble", 64'(instr_a), 64'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("fl2");

    // flush while ONE with a real accept in the same cycle
    drive(1'b1, 32'h30, 32'h3333_0030, 1'b0, 1'b0);
    tick("fo0");
    drive(1'b1, 32'h34, 32'h3333_0034, 1'b0, 1'b1);
    tick("fl_one");
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("fo1");

    // saturation of the 4-bit counter, untouched by flush
    do_reset("sat");
    drive(1'b1, 32'h40, 32'h4444_0040, 1'b0, 1'b0);
    tick("sat.load");
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick("sat");
    chk("sat.stop15", 64'(stall_b), 64'd15);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick("sat.flush");
    chk("sat.after_flush", 64'(stall_b), 64'd15);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
